execute_stage: RTL

- Execute stage of the 16-bit pipelined CPU.
- Consumes the registered aluOp/srcA/srcB produced by the Decode/Execute pipeline register.
- Single-cycle ops: computes and registers the result toward the Execute/Memory stage.
- MUL/DIV/MOD: runs an iterative multi-cycle unit and raises a stall to freeze the upstream pipeline.

---
 rtl/execute_stage.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage of the 16-bit pipelined CPU.
// Single-cycle ALU ops register their result one edge after issue. MUL/DIV/MOD
// use an iterative shift-add / restoring-divide unit and stall upstream.
// Build option: define EXEC_MULDIV_EN to build the iterative MUL/DIV/MOD unit;
// without it ops 8-10 finish in one cycle with result 0 and stall_out is 0.
module execute_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ITER   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [3:0]        aluOp,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  output logic [DATA_W-1:0] result_out,
  output logic              valid_out,
  output logic              zero_out,
  output logic              neg_out,
  output logic              div0_out,
  output logic              stall_out
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_DIV   = 4'd9;
  localparam logic [3:0] OP_MOD   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;
  localparam logic [3:0] OP_SLT   = 4'd12;

  // The iterative unit produces one quotient/product bit per step.
  if (ITER != DATA_W) begin : g_iter_check
    $error("execute_stage: ITER must equal DATA_W");
  end

  logic [DATA_W-1:0] sc_result;
  logic              sc_div0;
  logic              accept;
  logic              is_multi;
  logic              mc_done;
  logic [DATA_W-1:0] mc_result;

  // Single-cycle ALU, including the divide-by-zero shortcuts.
  always_comb begin
    sc_result = '0;
    sc_div0   = 1'b0;
    case (aluOp)
      OP_ADD:   sc_result = srcA + srcB;
      OP_SUB:   sc_result = srcA - srcB;
      OP_AND:   sc_result = srcA & srcB;
      OP_OR:    sc_result = srcA | srcB;
      OP_XOR:   sc_result = srcA ^ srcB;
      OP_SLL:   sc_result = srcA << srcB[3:0];
      OP_SRL:   sc_result = srcA >> srcB[3:0];
      OP_SRA:   sc_result = DATA_W'($signed(srcA) >>> srcB[3:0]);
      OP_MUL:   sc_result = '0;
      OP_DIV: begin
`ifdef EXEC_MULDIV_EN
        if (srcB == '0) begin
          sc_result = '1;
          sc_div0   = 1'b1;
        end
`endif
      end
      OP_MOD: begin
`ifdef EXEC_MULDIV_EN
        if (srcB == '0) begin
          sc_result = srcA;
          sc_div0   = 1'b1;
        end
`endif
      end
      OP_PASSB: sc_result = srcB;
      OP_SLT:   sc_result = {{(DATA_W-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default:  sc_result = '0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] step_a;
  logic [DATA_W-1:0] step_b;
  logic [DATA_W-1:0] step_acc;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W-1:0] rem_diff;
  logic              start;
  logic              last_step;

  assign is_multi  = (aluOp == OP_MUL) ||
                     (((aluOp == OP_DIV) || (aluOp == OP_MOD)) && (srcB != '0));
  assign accept    = valid_in && !flush && ((state == S_IDLE) || (state == S_DONE));
  assign start     = accept && is_multi;
  assign last_step = (state == S_BUSY) && (count_q == CNT_W'(1));
  assign mc_done   = last_step && !flush;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: state_next = start ? S_BUSY : S_IDLE;
        S_BUSY:         state_next = last_step ? S_DONE : S_BUSY;
        default:        state_next = S_IDLE;
      endcase
    end
  end

  // Stall covers the issue cycle and every BUSY cycle but the last, so the
  // upstream register advances exactly as the result is written.
  always_comb begin
    stall_out = 1'b0;
    if (!rst && !flush) begin
      stall_out = start || ((state == S_BUSY) && !last_step);
    end
  end

  // One shift-add (MUL) or restoring-subtract (DIV/MOD) step.
  always_comb begin
    step_a    = a_q;
    step_b    = b_q;
    step_acc  = acc_q;
    rem_shift = {acc_q, a_q[DATA_W-1]};
    rem_diff  = DATA_W'(rem_shift - {1'b0, b_q});
    if (op_q == OP_MUL) begin
      step_acc = b_q[0] ? (acc_q + a_q) : acc_q;
      step_a   = a_q << 1;
      step_b   = b_q >> 1;
    end else begin
      step_a = {a_q[DATA_W-2:0], 1'b0};
      if (rem_shift >= {1'b0, b_q}) begin
        step_acc  = rem_diff;
        step_a[0] = 1'b1;
      end else begin
        step_acc = rem_shift[DATA_W-1:0];
      end
    end
  end

  // Final-step result: product, quotient or remainder.
  always_comb begin
    case (op_q)
      OP_DIV:  mc_result = step_a;
      default: mc_result = step_acc;
    endcase
  end

  // Iterative unit operand/accumulator/counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (start) begin
      op_q    <= aluOp;
      a_q     <= srcA;
      b_q     <= srcB;
      acc_q   <= '0;
      count_q <= CNT_W'(ITER);
    end else if ((state == S_BUSY) && !flush) begin
      a_q     <= step_a;
      b_q     <= step_b;
      acc_q   <= step_acc;
      count_q <= count_q - CNT_W'(1);
    end
  end
`else
  assign is_multi  = 1'b0;
  assign accept    = valid_in && !flush;
  assign mc_done   = 1'b0;
  assign mc_result = '0;
  assign stall_out = 1'b0;
`endif

  // Result and flag registers; flags are only non-zero alongside valid_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_out <= '0;
      valid_out  <= 1'b0;
      zero_out   <= 1'b0;
      neg_out    <= 1'b0;
      div0_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      zero_out  <= 1'b0;
      neg_out   <= 1'b0;
      div0_out  <= 1'b0;
      if (mc_done) begin
        result_out <= mc_result;
        valid_out  <= 1'b1;
        zero_out   <= (mc_result == '0);
        neg_out    <= mc_result[DATA_W-1];
      end else if (accept && !is_multi) begin
        result_out <= sc_result;
        valid_out  <= 1'b1;
        zero_out   <= (sc_result == '0);
        neg_out    <= sc_result[DATA_W-1];
        div0_out   <= sc_div0;
      end
    end
  end

endmodule
